// File: rtl/branch_pc_unit.sv
// PC sequencer sitting in front of the ALU: run/halt control, branch resolution
// against the previous compare's flags, one bubble per taken branch, retired-instruction count.
module branch_pc_unit #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic [3:0]       opcode_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic             alu_zero_i,
    input  logic             alu_neg_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             fetch_valid_o,
    output logic             taken_o,
    output logic             done_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [3:0] OP_KB   = 4'b1010;
    localparam logic [3:0] OP_KBEQ = 4'b1011;
    localparam logic [3:0] OP_KBLT = 4'b1100;
    localparam logic [3:0] OP_KBGE = 4'b1101;
    localparam logic [3:0] OP_KBGT = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_HALT
    } state_t;

    state_t           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] retired_q;
    logic             fetch_valid_q;
    logic             done_q;

    logic             cond_hit;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  target_d;
    logic [PC_W-1:0]  pc_inc_d;
    logic [CNT_W-1:0] retired_inc_d;

    // Condition evaluation; non-branch opcodes (incl. the undefined 1110) never hit.
    always_comb begin
        cond_hit = 1'b0;
        unique case (opcode_i)
            OP_KB:   cond_hit = 1'b1;
            OP_KBEQ: cond_hit = alu_zero_i;
            OP_KBLT: cond_hit = alu_neg_i;
            OP_KBGE: cond_hit = !alu_neg_i;
            OP_KBGT: cond_hit = !alu_neg_i && !alu_zero_i;
            default: cond_hit = 1'b0;
        endcase
    end

    assign off_ext       = PC_W'($signed(offset_i));
    assign target_d      = pc_q + off_ext;
    assign pc_inc_d      = pc_q + PC_W'(1);
    // Counter sticks at all-ones rather than wrapping.
    assign retired_inc_d = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);

    // Halt outranks a branch in the same instruction.
    assign taken_o = fetch_valid_q && !halt_i && cond_hit;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            retired_q     <= '0;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALT: begin
                    if (start_i) begin
                        state_q       <= S_RUN;
                        pc_q          <= '0;
                        retired_q     <= '0;
                        fetch_valid_q <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                S_RUN: begin
                    retired_q <= retired_inc_d;
                    if (halt_i) begin
                        state_q       <= S_HALT;
                        fetch_valid_q <= 1'b0;
                        done_q        <= 1'b1;
                    end else if (cond_hit) begin
                        state_q       <= S_FLUSH;
                        pc_q          <= target_d;
                        fetch_valid_q <= 1'b0;
                    end else begin
                        pc_q <= pc_inc_d;
                    end
                end
                S_FLUSH: begin
                    state_q       <= S_RUN;
                    fetch_valid_q <= 1'b1;
                end
                default: begin
                    state_q       <= S_IDLE;
                    fetch_valid_q <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = fetch_valid_q;
    assign done_o        = done_q;
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed program sequences, a behavioural reference checked
// every cycle, and literal spot checks. A narrow-counter twin exercises saturation.
module tb_branch_pc_unit;

    localparam int PC_W    = 10;
    localparam int OFF_W   = 6;
    localparam int CNT_W   = 16;
    localparam int PC_SPAN = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int SCNT_MAX = 7;

    localparam logic [3:0] KADD = 4'b0001;
    localparam logic [3:0] KB   = 4'b1010;
    localparam logic [3:0] KBEQ = 4'b1011;
    localparam logic [3:0] KBLT = 4'b1100;
    localparam logic [3:0] KBGE = 4'b1101;
    localparam logic [3:0] KBGT = 4'b1111;

    logic             CLK = 1'b0;
    logic             Reset;
    logic             start_i, halt_i, alu_zero_i, alu_neg_i;
    logic [3:0]       opcode_i;
    logic [OFF_W-1:0] offset_i;
    logic [PC_W-1:0]  pc_o, pc_s;
    logic             fetch_valid_o, taken_o, done_o;
    logic             fv_s, tk_s, dn_s;
    logic [CNT_W-1:0] retired_o;
    logic [2:0]       retired_s;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    branch_pc_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .start_i(start_i), .halt_i(halt_i),
        .opcode_i(opcode_i), .offset_i(offset_i), .alu_zero_i(alu_zero_i),
        .alu_neg_i(alu_neg_i), .pc_o(pc_o), .fetch_valid_o(fetch_valid_o),
        .taken_o(taken_o), .done_o(done_o), .retired_o(retired_o)
    );

    branch_pc_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(3)) dut_s (
        .CLK(CLK), .Reset(Reset), .start_i(start_i), .halt_i(halt_i),
        .opcode_i(opcode_i), .offset_i(offset_i), .alu_zero_i(alu_zero_i),
        .alu_neg_i(alu_neg_i), .pc_o(pc_s), .fetch_valid_o(fv_s),
        .taken_o(tk_s), .done_o(dn_s), .retired_o(retired_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: which instructions execute, where the PC goes, how many retired.
    bit m_run = 0, m_bub = 0, m_halt = 0;
    int m_pc = 0, m_cnt = 0;

    function automatic bit rule_taken(input logic [3:0] op, input logic z, input logic n);
        case (op)
            KB:      return 1'b1;
            KBEQ:    return z;
            KBLT:    return n;
            KBGE:    return !n;
            KBGT:    return !n && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int wrap_pc(input int x);
        return ((x % PC_SPAN) + PC_SPAN) % PC_SPAN;
    endfunction

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    always @(posedge CLK) begin
        if (Reset) begin
            m_run <= 0; m_bub <= 0; m_halt <= 0; m_pc <= 0; m_cnt <= 0;
        end else if (m_run) begin
            m_cnt <= m_cnt + 1;
            if (halt_i) begin
                m_run <= 0; m_halt <= 1;
            end else if (rule_taken(opcode_i, alu_zero_i, alu_neg_i)) begin
                m_run <= 0; m_bub <= 1;
                m_pc  <= wrap_pc(m_pc + int'($signed(offset_i)));
            end else begin
                m_pc <= wrap_pc(m_pc + 1);
            end
        end else if (m_bub) begin
            m_bub <= 0; m_run <= 1;
        end else if (start_i) begin
            m_run <= 1; m_halt <= 0; m_pc <= 0; m_cnt <= 0;
        end
    end

    always @(negedge CLK) begin
        chk("pc", int'(pc_o), m_pc);
        chk("fetch_valid", int'(fetch_valid_o), int'(m_run));
        chk("done", int'(done_o), int'(m_halt));
        chk("taken", int'(taken_o), int'(m_run && !halt_i && rule_taken(opcode_i, alu_zero_i, alu_neg_i)));
        chk("retired", int'(retired_o), sat(m_cnt, CNT_MAX));
        chk("retired_narrow", int'(retired_s), sat(m_cnt, SCNT_MAX));
    end

    task automatic step(input logic h, input logic [3:0] op, input logic [OFF_W-1:0] off,
                        input logic z, input logic n);
        halt_i = h; opcode_i = op; offset_i = off; alu_zero_i = z; alu_neg_i = n;
        @(posedge CLK); #1;
    endtask

    task automatic nop();
        step(1'b0, KADD, '0, 1'b0, 1'b0);
    endtask

    task automatic go();
        start_i = 1'b1; nop(); start_i = 1'b0;
    endtask

    logic [3:0] sweep_op [7];
    logic [3:0] sweep_mask [7];
    logic [1:0] zn;

    initial begin
        Reset = 1'b1; start_i = 1'b0; halt_i = 1'b0; opcode_i = KADD;
        offset_i = '0; alu_zero_i = 1'b0; alu_neg_i = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_pc", int'(pc_o), 0);
        chk("reset_fv", int'(fetch_valid_o), 0);
        chk("reset_done", int'(done_o), 0);
        chk("reset_ret", int'(retired_o), 0);
        Reset = 1'b0;
        nop();
        chk("idle_fv", int'(fetch_valid_o), 0);

        // 1: straight-line program then halt
        go();
        chk("t1_pc0", int'(pc_o), 0);
        chk("t1_fv", int'(fetch_valid_o), 1);
        repeat (5) nop();
        chk("t1_pc5", int'(pc_o), 5);
        step(1'b1, KADD, '0, 1'b0, 1'b0);
        chk("t1_done", int'(done_o), 1);
        chk("t1_ret", int'(retired_o), 6);
        chk("t1_hold", int'(pc_o), 5);
        nop();
        chk("t1_hold2", int'(pc_o), 5);

        // 2: conditional forward branch, taken then not taken
        go();
        repeat (3) nop();
        halt_i = 0; opcode_i = KBEQ; offset_i = 6'd4; alu_zero_i = 1; alu_neg_i = 0;
        #1 chk("t2_taken", int'(taken_o), 1);
        @(posedge CLK); #1;
        chk("t2_flush_fv", int'(fetch_valid_o), 0);
        chk("t2_flush_pc", int'(pc_o), 7);
        halt_i = 1; opcode_i = KB;
        #1 chk("t2_flush_tk", int'(taken_o), 0);
        @(posedge CLK); #1;
        chk("t2_run_fv", int'(fetch_valid_o), 1);
        chk("t2_run_pc", int'(pc_o), 7);
        step(1'b0, KB, 6'b111100, 1'b0, 1'b0);
        nop();
        chk("t2_back3", int'(pc_o), 3);
        step(1'b0, KBEQ, 6'd4, 1'b0, 1'b0);
        chk("t2_nt_pc", int'(pc_o), 4);
        chk("t2_nt_fv", int'(fetch_valid_o), 1);

        // 3: backward branches and PC wrap both ways
        step(1'b0, KB, 6'b111110, 1'b0, 1'b0);
        nop();
        chk("t3_pc2", int'(pc_o), 2);
        step(1'b0, KB, 6'b111110, 1'b0, 1'b0);
        chk("t3_pc0", int'(pc_o), 0);
        nop();
        step(1'b0, KB, 6'b111111, 1'b0, 1'b0);
        chk("t3_pc3ff", int'(pc_o), 1023);
        nop();
        nop();
        chk("t3_wrap", int'(pc_o), 0);

        // 4: condition table sweep; mask bit index is {zero,neg}
        sweep_op   = '{KBLT, KBGE, KBGT, KBEQ, KB, 4'b1110, 4'b0010};
        sweep_mask = '{4'b1010, 4'b0101, 4'b0001, 4'b1100, 4'b1111, 4'b0000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 4; j++) begin
                zn = 2'(j);
                halt_i = 0; opcode_i = sweep_op[i]; offset_i = 6'd1;
                alu_zero_i = zn[1]; alu_neg_i = zn[0];
                #1 chk($sformatf("t4_op%0h_zn%0d", sweep_op[i], j), int'(taken_o), int'(sweep_mask[i][j]));
                @(posedge CLK); #1;
                if (sweep_mask[i][j]) nop();
            end
        end

        // 5: halt beats a taken branch; restart clears
        step(1'b1, KADD, '0, 1'b0, 1'b0);
        go();
        repeat (2) nop();
        halt_i = 1; opcode_i = KB; offset_i = 6'd5;
        #1 chk("t5_taken", int'(taken_o), 0);
        @(posedge CLK); #1;
        chk("t5_done", int'(done_o), 1);
        chk("t5_pc", int'(pc_o), 2);
        chk("t5_ret", int'(retired_o), 3);
        go();
        chk("t5_rs_pc", int'(pc_o), 0);
        chk("t5_rs_ret", int'(retired_o), 0);
        chk("t5_rs_done", int'(done_o), 0);

        // 6: reset during FLUSH, then counter saturation (narrow twin)
        step(1'b0, KB, 6'd3, 1'b0, 1'b0);
        chk("t6_flush", int'(fetch_valid_o), 0);
        Reset = 1'b1;
        nop();
        Reset = 1'b0;
        chk("t6_rst_pc", int'(pc_o), 0);
        chk("t6_rst_ret", int'(retired_o), 0);
        chk("t6_rst_fv", int'(fetch_valid_o), 0);
        nop();
        go();
        start_i = 1'b1;
        repeat (2) nop();
        start_i = 1'b0;
        chk("t6_start_ign", int'(pc_o), 2);
        repeat (7) nop();
        chk("t6_ret9", int'(retired_o), 9);
        chk("t6_sat", int'(retired_s), 7);
        step(1'b1, KADD, '0, 1'b0, 1'b0);
        chk("t6_sat_hold", int'(retired_s), 7);
        chk("t6_ret10", int'(retired_o), 10);
        nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
